// File: rtl/alarm_clock_pkg.sv
// ============================================================================
// Module      : alarm_clock_pkg
// Description : Shared FSM states, key/BCD limits and the HH:MM range check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alarm_clock_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ENTRY      = 3'd1,
        SHOW_ALARM = 3'd2,
        LOAD_ALARM = 3'd3,
        LOAD_TIME  = 3'd4
    } state_e;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
    localparam logic [3:0] MS_HR_MAX     = 4'd2;
    localparam logic [3:0] LS_HR_MAX_24  = 4'd3;
    localparam logic [3:0] MS_MIN_MAX    = 4'd5;
    localparam logic [3:0] DIGIT_MAX     = 4'd9;
    localparam logic [2:0] DIGIT_COUNT   = 3'd4;

    // Hours 20-23 cap the units digit at 3; otherwise any BCD digit is allowed.
    function automatic logic valid_time(input logic [3:0] ms_hr,
                                        input logic [3:0] ls_hr,
                                        input logic [3:0] ms_min,
                                        input logic [3:0] ls_min);
        logic [3:0] ls_hr_max;
        ls_hr_max = (ms_hr == MS_HR_MAX) ? LS_HR_MAX_24 : DIGIT_MAX;
        return (ms_hr <= MS_HR_MAX) && (ls_hr <= ls_hr_max) &&
               (ms_min <= MS_MIN_MAX) && (ls_min <= DIGIT_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_key_shift.sv
// ============================================================================
// Module      : alarm_key_shift
// Description : 4-digit BCD shift buffer with saturating digit count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_key_shift
    import alarm_clock_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       shift_i,
    input  logic [3:0] key_i,
    output logic [3:0] ms_hr_o,
    output logic [3:0] ls_hr_o,
    output logic [3:0] ms_min_o,
    output logic [3:0] ls_min_o,
    output logic [2:0] count_o
);

    logic [3:0] ms_hr_q, ls_hr_q, ms_min_q, ls_min_q;
    logic [3:0] ms_hr_d, ls_hr_d, ms_min_d, ls_min_d;
    logic [2:0] count_q, count_d;

    // clear together with shift starts a fresh entry holding just the new key
    always_comb begin
        ms_hr_d  = ms_hr_q;
        ls_hr_d  = ls_hr_q;
        ms_min_d = ms_min_q;
        ls_min_d = ls_min_q;
        count_d  = count_q;
        if (clear_i) begin
            ms_hr_d  = 4'd0;
            ls_hr_d  = 4'd0;
            ms_min_d = 4'd0;
            ls_min_d = 4'd0;
            count_d  = 3'd0;
        end
        if (shift_i) begin
            ms_hr_d  = clear_i ? 4'd0 : ls_hr_q;
            ls_hr_d  = clear_i ? 4'd0 : ms_min_q;
            ms_min_d = clear_i ? 4'd0 : ls_min_q;
            ls_min_d = key_i;
            if (clear_i)
                count_d = 3'd1;
            else if (count_q != DIGIT_COUNT)
                count_d = count_q + 3'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ms_hr_q  <= 4'd0;
            ls_hr_q  <= 4'd0;
            ms_min_q <= 4'd0;
            ls_min_q <= 4'd0;
            count_q  <= 3'd0;
        end else begin
            ms_hr_q  <= ms_hr_d;
            ls_hr_q  <= ls_hr_d;
            ms_min_q <= ms_min_d;
            ls_min_q <= ls_min_d;
            count_q  <= count_d;
        end
    end

    assign ms_hr_o  = ms_hr_q;
    assign ls_hr_o  = ls_hr_q;
    assign ms_min_o = ms_min_q;
    assign ls_min_o = ls_min_q;
    assign count_o  = count_q;

endmodule

`default_nettype wire

// File: rtl/alarm_key_entry.sv
// ============================================================================
// Module      : alarm_key_entry
// Description : Keypad HH:MM entry FSM with range check, load strobes and
//               display select. Optional ENTRY_TIMEOUT_EN abandons idle entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_key_entry
    import alarm_clock_pkg::*;
#(
    parameter int unsigned TIMEOUT_SEC = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key,
    input  logic       key_valid,
    input  logic       alarm_button,
    input  logic       time_button,
    input  logic       one_second,
    output logic [3:0] new_alarm_ms_hr,
    output logic [3:0] new_alarm_ls_hr,
    output logic [3:0] new_alarm_ms_min,
    output logic [3:0] new_alarm_ls_min,
    output logic       load_new_alarm,
    output logic       load_new_time,
    output logic       show_new_time,
    output logic       show_alarm,
    output logic       entry_error
);

    state_e     state_q, state_d;
    logic       err_q, err_d;
    logic       clear_w, shift_w;
    logic       digit_w, full_ok_w, timeout_w;
    logic [2:0] count_w;

    assign digit_w = key_valid && (key <= KEY_DIGIT_MAX);

    alarm_key_shift u_shift (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (clear_w),
        .shift_i  (shift_w),
        .key_i    (key),
        .ms_hr_o  (new_alarm_ms_hr),
        .ls_hr_o  (new_alarm_ls_hr),
        .ms_min_o (new_alarm_ms_min),
        .ls_min_o (new_alarm_ls_min),
        .count_o  (count_w)
    );

    assign full_ok_w = (count_w == DIGIT_COUNT) &&
                       valid_time(new_alarm_ms_hr, new_alarm_ls_hr,
                                  new_alarm_ms_min, new_alarm_ls_min);

`ifdef ENTRY_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_SEC + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_SEC - 1);

    logic [TIMER_W-1:0] timer_q, timer_d;

    // Digits and buttons outrank the final tick.
    assign timeout_w = (state_q == ENTRY) && one_second && !digit_w &&
                       !alarm_button && !time_button && (timer_q == TIMER_LAST);

    always_comb begin
        timer_d = timer_q;
        if ((state_q != ENTRY) || digit_w || timeout_w)
            timer_d = '0;
        else if (one_second)
            timer_d = timer_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            timer_q <= '0;
        else
            timer_q <= timer_d;
    end
`else
    logic unused_w;
    assign unused_w  = one_second ^ (TIMEOUT_SEC != 0);
    assign timeout_w = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        clear_w = 1'b0;
        shift_w = 1'b0;
        case (state_q)
            IDLE: begin
                if (digit_w) begin
                    clear_w = 1'b1;
                    shift_w = 1'b1;
                    state_d = ENTRY;
                end else if (alarm_button) begin
                    state_d = SHOW_ALARM;
                end
            end
            SHOW_ALARM: begin
                if (!alarm_button)
                    state_d = IDLE;
            end
            ENTRY: begin
                if (digit_w) begin
                    shift_w = 1'b1;
                end else if (alarm_button || time_button) begin
                    if (full_ok_w) begin
                        state_d = alarm_button ? LOAD_ALARM : LOAD_TIME;
                    end else begin
                        err_d   = 1'b1;
                        clear_w = 1'b1;
                        state_d = IDLE;
                    end
                end else if (timeout_w) begin
                    clear_w = 1'b1;
                    state_d = IDLE;
                end
            end
            LOAD_ALARM: state_d = IDLE;
            LOAD_TIME:  state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign load_new_alarm = (state_q == LOAD_ALARM);
    assign load_new_time  = (state_q == LOAD_TIME);
    assign show_new_time  = (state_q == ENTRY);
    assign show_alarm     = (state_q == SHOW_ALARM);
    assign entry_error    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_alarm_key_entry.sv
// ============================================================================
// Module      : tb_alarm_key_entry
// Description : Scoreboard bench for alarm_key_entry (honours ENTRY_TIMEOUT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alarm_key_entry;

`ifdef ENTRY_TIMEOUT_EN
    localparam int unsigned TO_SEC = 3;
`else
    localparam int unsigned TO_SEC = 10;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] key = 4'd0;
    logic       key_valid = 1'b0;
    logic       alarm_button = 1'b0;
    logic       time_button = 1'b0;
    logic       one_second = 1'b0;
    logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
    logic       load_new_alarm, load_new_time, show_new_time, show_alarm, entry_error;

    alarm_key_entry #(.TIMEOUT_SEC(TO_SEC)) dut (
        .clock            (clock),
        .reset            (reset),
        .key              (key),
        .key_valid        (key_valid),
        .alarm_button     (alarm_button),
        .time_button      (time_button),
        .one_second       (one_second),
        .new_alarm_ms_hr  (ms_hr),
        .new_alarm_ls_hr  (ls_hr),
        .new_alarm_ms_min (ms_min),
        .new_alarm_ls_min (ls_min),
        .load_new_alarm   (load_new_alarm),
        .load_new_time    (load_new_time),
        .show_new_time    (show_new_time),
        .show_alarm       (show_alarm),
        .entry_error      (entry_error)
    );

    always #5 clock = ~clock;

    // {load_new_alarm, load_new_time, entry_error, digits}
    typedef logic [18:0] ev_t;
    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    wire [15:0] dig = {ms_hr, ls_hr, ms_min, ls_min};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        key = 4'd0;
    endtask

    task automatic press4(input logic [15:0] d);
        press(d[15:12]);
        press(d[11:8]);
        press(d[7:4]);
        press(d[3:0]);
    endtask

    task automatic wait_event(output ev_t obs, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (load_new_alarm || load_new_time || entry_error) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
        obs = {load_new_alarm, load_new_time, entry_error, dig};
    endtask

    function automatic bit tb_valid(input logic [15:0] d);
        int h, m;
        h = int'(d[15:12]) * 10 + int'(d[11:8]);
        m = int'(d[7:4]) * 10 + int'(d[3:0]);
        return (d[15:12] <= 9) && (d[11:8] <= 9) && (d[7:4] <= 9) &&
               (d[3:0] <= 9) && (h < 24) && (m < 60);
    endfunction

    task automatic test_reset();
        n_cmp++;
        if ({dig, load_new_alarm, load_new_time, show_new_time, show_alarm, entry_error} !== 21'd0) begin
            n_bad++;
            $display("FAIL reset_state: got dig=%h flags=%b, want all 0", dig,
                     {load_new_alarm, load_new_time, show_new_time, show_alarm, entry_error});
        end
        press(4'd1);
        press(4'd2);
        n_cmp++;
        if ({show_new_time, dig} !== {1'b1, 16'h0012}) begin
            n_bad++;
            $display("FAIL entry_12: got show=%b dig=%h, want 1 0012", show_new_time, dig);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({show_new_time, dig} !== 17'd0) begin
            n_bad++;
            $display("FAIL async_reset: got show=%b dig=%h, want 0 0000", show_new_time, dig);
        end
        #1 reset = 1'b0;
        tick();
        n_cmp++;
        if ({show_new_time, show_alarm, dig} !== 18'd0) begin
            n_bad++;
            $display("FAIL post_reset_idle: got show=%b alarm=%b dig=%h, want 0 0 0000",
                     show_new_time, show_alarm, dig);
        end
    endtask

    task automatic test_reset_during_load();
        press4(16'h0730);
        alarm_button = 1'b1;
        tick();
        n_cmp++;
        if (load_new_alarm !== 1'b1) begin
            n_bad++;
            $display("FAIL load_before_reset: got %b, want 1", load_new_alarm);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (load_new_alarm !== 1'b0) begin
            n_bad++;
            $display("FAIL strobe_drop_on_reset: got %b, want 0", load_new_alarm);
        end
        alarm_button = 1'b0;
        #1 reset = 1'b0;
        tick();
        n_cmp++;
        if ({show_alarm, dig} !== 17'd0) begin
            n_bad++;
            $display("FAIL reset_load_clean: got alarm=%b dig=%h, want 0 0000", show_alarm, dig);
        end
    endtask

    task automatic test_load_alarm();
        ev_t obs, ex;
        bit  to;
        press4(16'h0730);
        alarm_button = 1'b1;
        exp_q.push_back({1'b1, 1'b0, 1'b0, 16'h0730});
        tick();
        wait_event(obs, to);
        ex = exp_q.pop_front();
        n_cmp++;
        if (to || obs !== ex) begin
            n_bad++;
            $display("FAIL load_alarm_0730: got %h (timeout=%0d), want %h", obs, to, ex);
        end
        tick();
        n_cmp++;
        if ({load_new_alarm, load_new_time, show_alarm} !== 3'b000) begin
            n_bad++;
            $display("FAIL load_one_cycle: got la=%b lt=%b sa=%b, want 000",
                     load_new_alarm, load_new_time, show_alarm);
        end
        tick();
        n_cmp++;
        if ({show_alarm, dig} !== {1'b1, 16'h0730}) begin
            n_bad++;
            $display("FAIL show_after_load: got sa=%b dig=%h, want 1 0730", show_alarm, dig);
        end
        press(4'd9);
        n_cmp++;
        if ({show_alarm, show_new_time, dig} !== {2'b10, 16'h0730}) begin
            n_bad++;
            $display("FAIL digit_in_show: got sa=%b st=%b dig=%h, want 1 0 0730",
                     show_alarm, show_new_time, dig);
        end
        alarm_button = 1'b0;
        tick();
        n_cmp++;
        if (show_alarm !== 1'b0) begin
            n_bad++;
            $display("FAIL show_release: got %b, want 0", show_alarm);
        end
    endtask

    task automatic test_error_cases();
        ev_t obs, ex;
        bit  to;
        press4(16'h2400);
        time_button = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 1'b1, 16'h0000});
        tick();
        wait_event(obs, to);
        ex = exp_q.pop_front();
        n_cmp++;
        if (to || obs !== ex) begin
            n_bad++;
            $display("FAIL reject_2400: got %h (timeout=%0d), want %h", obs, to, ex);
        end
        time_button = 1'b0;
        tick();
        n_cmp++;
        if ({entry_error, show_new_time, load_new_time} !== 3'b000) begin
            n_bad++;
            $display("FAIL error_one_cycle: got err=%b st=%b lt=%b, want 000",
                     entry_error, show_new_time, load_new_time);
        end
        press(4'd1);
        press(4'd2);
        alarm_button = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 1'b1, 16'h0000});
        tick();
        wait_event(obs, to);
        ex = exp_q.pop_front();
        n_cmp++;
        if (to || obs !== ex) begin
            n_bad++;
            $display("FAIL reject_short: got %h (timeout=%0d), want %h", obs, to, ex);
        end
        alarm_button = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_overflow();
        ev_t obs, ex;
        bit  to;
        press(4'd1);
        press4(16'h2345);
        time_button = 1'b1;
        exp_q.push_back({1'b0, 1'b1, 1'b0, 16'h2345});
        tick();
        wait_event(obs, to);
        ex = exp_q.pop_front();
        n_cmp++;
        if (to || obs !== ex) begin
            n_bad++;
            $display("FAIL load_time_2345: got %h (timeout=%0d), want %h", obs, to, ex);
        end
        time_button = 1'b0;
        tick();
        n_cmp++;
        if ({load_new_time, dig} !== {1'b0, 16'h2345}) begin
            n_bad++;
            $display("FAIL time_one_cycle_hold: got lt=%b dig=%h, want 0 2345", load_new_time, dig);
        end
    endtask

    typedef struct {
        logic [15:0] d;
        logic        ab;
        logic        tb;
    } tcase_t;

    task automatic test_boundaries();
        tcase_t tc[7];
        ev_t    obs, ex;
        bit     to;
        tc[0] = '{16'h2359, 1'b1, 1'b0};
        tc[1] = '{16'h1959, 1'b0, 1'b1};
        tc[2] = '{16'h0060, 1'b1, 1'b0};
        tc[3] = '{16'h3000, 1'b0, 1'b1};
        tc[4] = '{16'h1200, 1'b1, 1'b1};
        tc[5] = '{16'h0000, 1'b0, 1'b1};
        tc[6] = '{16'h2400, 1'b1, 1'b1};
        foreach (tc[i]) begin
            press4(tc[i].d);
            // a non-digit key code must be ignored entirely
            key = 4'd12;
            key_valid = 1'b1;
            tick();
            key_valid = 1'b0;
            alarm_button = tc[i].ab;
            time_button  = tc[i].tb;
            if (tb_valid(tc[i].d))
                exp_q.push_back({tc[i].ab, !tc[i].ab, 1'b0, tc[i].d});
            else
                exp_q.push_back({1'b0, 1'b0, 1'b1, 16'h0000});
            tick();
            wait_event(obs, to);
            ex = exp_q.pop_front();
            n_cmp++;
            if (to || obs !== ex) begin
                n_bad++;
                $display("FAIL boundary_%h_ab%b_tb%b: got %h (timeout=%0d), want %h",
                         tc[i].d, tc[i].ab, tc[i].tb, obs, to, ex);
            end
            alarm_button = 1'b0;
            time_button  = 1'b0;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        ev_t obs, ex;
        bit  to;
        press4(16'h1230);
        key = 4'd4;
        key_valid = 1'b1;
        alarm_button = 1'b1;
        tick();
        key_valid = 1'b0;
        n_cmp++;
        if ({load_new_alarm, show_new_time, dig} !== {2'b01, 16'h2304}) begin
            n_bad++;
            $display("FAIL digit_beats_button: got la=%b st=%b dig=%h, want 0 1 2304",
                     load_new_alarm, show_new_time, dig);
        end
        exp_q.push_back({1'b1, 1'b0, 1'b0, 16'h2304});
        tick();
        wait_event(obs, to);
        ex = exp_q.pop_front();
        n_cmp++;
        if (to || obs !== ex) begin
            n_bad++;
            $display("FAIL load_2304: got %h (timeout=%0d), want %h", obs, to, ex);
        end
        alarm_button = 1'b0;
        tick();
        key = 4'd9;
        key_valid = 1'b1;
        time_button = 1'b1;
        tick();
        key_valid = 1'b0;
        time_button = 1'b0;
        n_cmp++;
        if ({show_new_time, entry_error, dig} !== {2'b10, 16'h0009}) begin
            n_bad++;
            $display("FAIL idle_digit_priority: got st=%b err=%b dig=%h, want 1 0 0009",
                     show_new_time, entry_error, dig);
        end
        press(4'd5);
        press(4'd0);
        press(4'd0);
        time_button = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 1'b1, 16'h0000});
        tick();
        wait_event(obs, to);
        ex = exp_q.pop_front();
        n_cmp++;
        if (to || obs !== ex) begin
            n_bad++;
            $display("FAIL reject_9500: got %h (timeout=%0d), want %h", obs, to, ex);
        end
        time_button = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
`ifdef ENTRY_TIMEOUT_EN
        press(4'd5);
        for (int i = 0; i < 3; i++) begin
            one_second = 1'b1;
            tick();
            one_second = 1'b0;
            if (i == 1) begin
                n_cmp++;
                if ({show_new_time, dig} !== {1'b1, 16'h0005}) begin
                    n_bad++;
                    $display("FAIL timeout_tick2_entry: got st=%b dig=%h, want 1 0005",
                             show_new_time, dig);
                end
            end
            if (i == 2) begin
                n_cmp++;
                if ({show_new_time, entry_error, dig} !== 18'd0) begin
                    n_bad++;
                    $display("FAIL timeout_abandon: got st=%b err=%b dig=%h, want 0 0 0000",
                             show_new_time, entry_error, dig);
                end
            end
            tick();
        end
        press(4'd5);
        one_second = 1'b1;
        tick();
        key = 4'd6;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        one_second = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            one_second = 1'b1;
            tick();
            one_second = 1'b0;
            n_cmp++;
            if (i < 2 && {show_new_time, dig} !== {1'b1, 16'h0056}) begin
                n_bad++;
                $display("FAIL timeout_restart_%0d: got st=%b dig=%h, want 1 0056",
                         i, show_new_time, dig);
            end else if (i == 2 && {show_new_time, entry_error, dig} !== 18'd0) begin
                n_bad++;
                $display("FAIL timeout_restart_abandon: got st=%b err=%b dig=%h, want 0 0 0000",
                         show_new_time, entry_error, dig);
            end
        end
        tick();
`else
        ev_t obs, ex;
        bit  to;
        press(4'd5);
        for (int i = 0; i < 12; i++) begin
            one_second = 1'b1;
            tick();
            one_second = 1'b0;
            tick();
        end
        n_cmp++;
        if ({show_new_time, dig} !== {1'b1, 16'h0005}) begin
            n_bad++;
            $display("FAIL no_timeout: got st=%b dig=%h, want 1 0005", show_new_time, dig);
        end
        time_button = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 1'b1, 16'h0000});
        tick();
        wait_event(obs, to);
        ex = exp_q.pop_front();
        n_cmp++;
        if (to || obs !== ex) begin
            n_bad++;
            $display("FAIL no_timeout_reject: got %h (timeout=%0d), want %h", obs, to, ex);
        end
        time_button = 1'b0;
        tick();
`endif
    endtask

    initial begin
        tick();
        tick();
        #3 reset = 1'b0;
        tick();
        test_reset();
        test_reset_during_load();
        test_load_alarm();
        test_error_cases();
        test_overflow();
        test_boundaries();
        test_back_to_back();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alarm_key_entry.md
Name: alarm_key_entry

Overview:
- Keypad entry controller for the alarm clock, directly upstream of the alarm register.
- Collects decimal key presses into a 4-digit BCD HH:MM buffer and range-checks it.
- On an alarm or time button press, drives the buffer onto the new-alarm digit bus with a one-cycle load_new_alarm or load_new_time strobe.
- Also generates the display-select flags.

Parameters:
TIMEOUT_SEC, 10, one_second ticks without a digit before ENTRY is abandoned (used only with ENTRY_TIMEOUT_EN)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
key  input  4  key code; 0-9 are digits, 10-15 are ignored
key_valid  input  1  one-cycle strobe qualifying key
alarm_button  input  1  level, synchronous to clock
time_button  input  1  level, synchronous to clock
one_second  input  1  one-cycle tick, once per second
new_alarm_ms_hr  output  4  buffer digit 3 (tens of hours)
new_alarm_ls_hr  output  4  buffer digit 2
new_alarm_ms_min  output  4  buffer digit 1
new_alarm_ls_min  output  4  buffer digit 0; the 16-bit bus also feeds the time counter load
load_new_alarm  output  1  one-cycle load strobe to the alarm register
load_new_time  output  1  one-cycle load strobe to the time counter
show_new_time  output  1  display shows key buffer
show_alarm  output  1  display shows stored alarm
entry_error  output  1  one-cycle pulse when a commit is rejected

Behaviour:
- Reset values:
  - state = IDLE.
  - All four digits, digit count and timer = 0.
  - All strobes and flags = 0.
  - Reset is honoured in any state, including mid-entry and during a load cycle; the strobe drops immediately.
- Digit accept: key_valid=1 and key<=9. Codes 10-15 with key_valid are ignored entirely (no shift, no timer clear).
- Shift on accept: ms_hr<=ls_hr, ls_hr<=ms_min, ms_min<=ls_min, ls_min<=key. Count saturates at 4; a 5th and later digit keeps shifting (the oldest digit drops).
- Valid time: ms_hr<=2; ls_hr<=9, or ls_hr<=3 if ms_hr==2; ms_min<=5; ls_min<=9.
- IDLE (all flags 0):
  - Accepted digit -> ENTRY. Buffer becomes 0,0,0,key; count=1; timer=0.
  - Else alarm_button=1 -> SHOW_ALARM.
  - A digit has priority over buttons in the same cycle.
- SHOW_ALARM (show_alarm=1):
  - Stays while alarm_button=1.
  - alarm_button=0 -> IDLE.
  - Digits are ignored in this state.
- ENTRY (show_new_time=1):
  - Accepted digit: shift, timer=0, stay in ENTRY. A digit beats a button in the same cycle.
  - alarm_button=1 with count==4 and valid -> LOAD_ALARM.
  - time_button=1 with count==4 and valid -> LOAD_TIME.
  - Both buttons together: alarm wins.
  - Any button with count<4 or invalid: entry_error=1 for one cycle, buffer cleared, -> IDLE.
- LOAD_ALARM: load_new_alarm=1 for exactly one cycle, digits stable -> IDLE. Buffer is held until the next entry starts.
- LOAD_TIME: as LOAD_ALARM, using load_new_time.
- Latency: load strobe is asserted the cycle after the qualifying button sample.
- IDLE after LOAD_ALARM with alarm_button still high -> SHOW_ALARM (intended: shows the new alarm).
- load_new_alarm and load_new_time are never asserted together.

Optional Feature:
ENTRY_TIMEOUT_EN
- Defined:
  - In ENTRY, the timer counts one_second ticks; it is cleared on every accepted digit.
  - On the TIMEOUT_SEC-th tick with no intervening digit: buffer and count cleared, -> IDLE next cycle, no entry_error.
  - A tick and a digit in the same cycle: the digit wins and the timer is cleared.
  - A button and the final tick in the same cycle: the button wins.
  - Timer width is clog2(TIMEOUT_SEC+1).
- Undefined: no timer logic; one_second is unused; ENTRY persists until a button or reset.

Decomposition:
- Shared package alarm_clock_pkg:
  - state enum (IDLE, ENTRY, SHOW_ALARM, LOAD_ALARM, LOAD_TIME)
  - key code limit 9
  - BCD limits: MS_HR_MAX=2, LS_HR_MAX_24=3, MS_MIN_MAX=5, DIGIT_MAX=9
- One sub-module, alarm_key_shift: 4-digit shift buffer plus saturating count, with clear/shift controls.
- FSM, timer and validity check stay in the top level.

Test Plan:
- Reset mid-ENTRY after keys 1,2 -> next cycle all digits 0, state IDLE, show_new_time=0.
- Keys 0,7,3,0 then alarm_button -> load_new_alarm high exactly one cycle, digits 0/7/3/0, then show_alarm=1 while button held.
- Keys 2,4,0,0 then time_button -> entry_error one cycle, no load strobe, buffer 0, IDLE.
- Keys 1,2,3,4,5 then time_button -> buffer 2,3,4,5, load_new_time one cycle.
- Keys 1,2 then alarm_button -> entry_error one cycle, no load.
- ENTRY_TIMEOUT_EN, TIMEOUT_SEC=3: key 5, three one_second ticks -> IDLE, buffer 0, no entry_error. A digit on tick 2 restarts the count.
